// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word layout, ALU op encodings and
// the architectural zero register index.
package pipeline_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the packed control word
    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[1:0], branch, jump}.
    localparam int CTRL_REG_WRITE = 8;
    localparam int CTRL_MEM_READ  = 7;
    localparam int CTRL_MEM_WRITE = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC   = 4;
    localparam int CTRL_ALU_OP_HI = 3;
    localparam int CTRL_ALU_OP_LO = 2;
    localparam int CTRL_BRANCH    = 1;
    localparam int CTRL_JUMP      = 0;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: hold > flush (bubble) > load, plus saturating
// bubble/stall counters and the feedback taps for load-use detection.
module id_ex_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              id_ex_flush,
    input  logic              branch_flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              id_ex_mem_read,
    output logic [4:0]        id_ex_rd,
    output logic [CNT_W-1:0]  bubble_count,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    logic   flush;
    logic   bubble_inc;

    assign flush      = id_ex_flush | branch_flush;
    assign bubble_inc = ~hold & flush;

    // NOTE: stage_d takes its hold value first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            if (flush) begin
                stage_d = '0;
            end else begin
                stage_d.valid    = id_valid;
                stage_d.pc       = id_pc;
                stage_d.rs1_data = id_rs1_data;
                stage_d.rs2_data = id_rs2_data;
                stage_d.imm      = id_imm;
                stage_d.rs1      = id_rs1;
                stage_d.rs2      = id_rs2;
                stage_d.funct3   = id_funct3;
                stage_d.funct7b5 = id_funct7b5;
                // An invalid slot must never advertise a load or a destination.
                stage_d.ctrl     = id_valid ? id_ctrl : '0;
                stage_d.rd       = id_valid ? id_rd : REG_ZERO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold),
        .count (stall_count)
    );

    assign ex_valid    = stage_q.valid;
    assign ex_pc       = stage_q.pc;
    assign ex_rs1_data = stage_q.rs1_data;
    assign ex_rs2_data = stage_q.rs2_data;
    assign ex_imm      = stage_q.imm;
    assign ex_rs1      = stage_q.rs1;
    assign ex_rs2      = stage_q.rs2;
    assign ex_funct3   = stage_q.funct3;
    assign ex_funct7b5 = stage_q.funct7b5;
    assign ex_ctrl     = stage_q.ctrl;

    // Hazard-detector taps depend on registered state only, never on inputs.
    assign id_ex_mem_read = stage_q.ctrl[CTRL_MEM_READ] & stage_q.valid;
    assign id_ex_rd       = stage_q.rd;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized bench for id_ex_pipeline_reg against a cycle-level reference
// model, plus directed reset, load-use, hold/flush and saturation scenarios.
module tb_id_ex_pipeline_reg;
    import pipeline_pkg::*;

    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold, id_ex_flush, branch_flush, id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic              id_funct7b5;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2;
    logic [2:0]        ex_funct3;
    logic              ex_funct7b5;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              id_ex_mem_read;
    logic [4:0]        id_ex_rd;
    logic [CNT_W-1:0]  bubble_count, stall_count;

    id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_ex_flush(id_ex_flush),
        .branch_flush(branch_flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_ctrl(id_ctrl), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_ctrl(ex_ctrl),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .bubble_count(bubble_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of what EX should hold, plus the two event tallies.
    logic              m_valid;
    logic [XLEN-1:0]   m_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]        m_rs1, m_rs2, m_rd;
    logic [2:0]        m_funct3;
    logic              m_funct7b5;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_bubbles, m_stalls;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        m_valid = 0; m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct3 = 0; m_funct7b5 = 0; m_ctrl = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model from current inputs.
    task automatic model_edge();
        if (hold) begin
            m_stalls = (m_stalls >= CNT_MAX) ? CNT_MAX : m_stalls + 1;
        end else if (id_ex_flush || branch_flush) begin
            model_clear();
            m_bubbles = (m_bubbles >= CNT_MAX) ? CNT_MAX : m_bubbles + 1;
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_rs1_data = id_rs1_data;
            m_rs2_data = id_rs2_data; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_funct3 = id_funct3; m_funct7b5 = id_funct7b5;
            m_ctrl = id_valid ? id_ctrl : '0;
            m_rd   = id_valid ? id_rd : 5'd0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ex_valid"},    64'(ex_valid),    64'(m_valid));
        check({tag, ".ex_pc"},       64'(ex_pc),       64'(m_pc));
        check({tag, ".ex_rs1_data"}, 64'(ex_rs1_data), 64'(m_rs1_data));
        check({tag, ".ex_rs2_data"}, 64'(ex_rs2_data), 64'(m_rs2_data));
        check({tag, ".ex_imm"},      64'(ex_imm),      64'(m_imm));
        check({tag, ".ex_rs1"},      64'(ex_rs1),      64'(m_rs1));
        check({tag, ".ex_rs2"},      64'(ex_rs2),      64'(m_rs2));
        check({tag, ".ex_funct3"},   64'(ex_funct3),   64'(m_funct3));
        check({tag, ".ex_funct7b5"}, 64'(ex_funct7b5), 64'(m_funct7b5));
        check({tag, ".ex_ctrl"},     64'(ex_ctrl),     64'(m_ctrl));
        check({tag, ".mem_read"},    64'(id_ex_mem_read), 64'(m_valid & m_ctrl[CTRL_MEM_READ]));
        check({tag, ".id_ex_rd"},    64'(id_ex_rd),    64'(m_rd));
        check({tag, ".bubble_cnt"},  64'(bubble_count), 64'(m_bubbles));
        check({tag, ".stall_cnt"},   64'(stall_count),  64'(m_stalls));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic rand_id();
        id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
        id_rs2_data = $urandom; id_imm = $urandom; id_rs1 = 5'($urandom);
        id_rs2 = 5'($urandom); id_rd = 5'($urandom); id_funct3 = 3'($urandom);
        id_funct7b5 = 1'($urandom); id_ctrl = CTRL_W'($urandom);
    endtask

    task automatic quiet();
        hold = 0; id_ex_flush = 0; branch_flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #3;
        model_clear();
        m_bubbles = 0; m_stalls = 0;
        compare_all("async_reset");
        @(posedge clk);
        #1;
        compare_all("reset_held");
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1; quiet(); rand_id();
        m_bubbles = 0; m_stalls = 0; model_clear();
        #2;
        // Reset with all control bits set must still show zero, without any edge.
        id_valid = 1; id_ctrl = 9'h1FF; id_rd = 5'd9;
        do_reset();
        step("release_load");
        check("release_valid", 64'(ex_valid), 64'd1);

        // Normal load of a memory-reading instruction.
        rand_id();
        id_valid = 1; id_rd = 5'd5; id_pc = 32'h100; id_ctrl = 9'h0;
        id_ctrl[CTRL_MEM_READ] = 1'b1;
        step("normal_load");
        check("nl_mem_read", 64'(id_ex_mem_read), 64'd1);
        check("nl_rd",       64'(id_ex_rd),       64'd5);
        check("nl_pc",       64'(ex_pc),          64'h100);

        // Invalid instruction never advertises control or rd.
        rand_id(); id_valid = 0; id_ctrl = 9'h1FF; id_rd = 5'd12;
        step("invalid_load");
        check("inv_rd", 64'(id_ex_rd), 64'd0);

        // Load-use bubble, then a normal load resumes.
        rand_id(); id_valid = 1; id_rd = 5'd7; id_ex_flush = 1;
        step("bubble");
        check("bub_valid", 64'(ex_valid), 64'd0);
        check("bub_rd",    64'(id_ex_rd), 64'd0);
        check("bub_ctrl",  64'(ex_ctrl),  64'd0);
        check("bub_count", 64'(bubble_count), 64'd1);
        quiet();
        step("after_bubble");
        check("ab_rd", 64'(id_ex_rd), 64'd7);

        // Hold beats flush for three cycles.
        for (int i = 0; i < 3; i++) begin
            rand_id(); hold = 1; id_ex_flush = 1;
            step("hold_vs_flush");
        end
        check("hvf_stall",  64'(stall_count),  64'd3);
        check("hvf_bubble", 64'(bubble_count), 64'd1);
        check("hvf_rd",     64'(id_ex_rd),     64'd7);
        quiet();

        // Both flush sources in one cycle count as a single bubble.
        rand_id(); id_ex_flush = 1; branch_flush = 1;
        step("double_flush");
        check("df_bubble", 64'(bubble_count), 64'd2);
        quiet();

        // Saturation of the bubble counter.
        for (int i = 0; i < 20; i++) begin
            rand_id(); branch_flush = 1'($urandom); id_ex_flush = ~branch_flush;
            step("saturate");
        end
        check("sat_bubble", 64'(bubble_count), 64'(CNT_MAX));
        quiet();

        // Reset in the middle of a held flush clears everything immediately.
        rand_id(); hold = 1; id_ex_flush = 1;
        do_reset();
        check("rst_bubble", 64'(bubble_count), 64'd0);
        quiet();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            hold         = ($urandom_range(0, 4) == 0);
            id_ex_flush  = ($urandom_range(0, 5) == 0);
            branch_flush = ($urandom_range(0, 7) == 0);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
